wheel_odometer: RTL and testbench

Downstream consumer of `wheel_speed`. On each window-end strobe it takes the per-window pulse count and accumulates total travelled distance in encoder pulses. It also keeps a moving-average speed over the last 2^AVG_LOG2 windows. Its registered outputs feed the odometry/pose stage.

---
 rtl/wheel_odometer.sv | 142 ++++++++++++++
 tb/tb_wheel_odometer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wheel_odometer.sv
// -----------------------------------------------------------------------------
// wheel_odometer
//
// Consumes the per-window pulse count produced by wheel_speed. Each window-end
// (rising edge of rst_flag) adds the count to a wrapping distance accumulator
// and pushes it into an N-deep ring buffer (N = 2^AVG_LOG2). The ring feeds a
// running sum from which a floor moving-average speed is taken.
//
// Parameters
//   CNT_W    width of the per-window pulse count
//   DIST_W   width of the distance accumulator (must be >= CNT_W)
//   AVG_LOG2 log2 of the moving-average depth, 1..4
//
// Ports
//   CLK            system clock, rising edge
//   RST_N          asynchronous active-low reset
//   pulses_number  pulse count of the window just closed
//   rst_flag       window-end flag; may be held high for several cycles
//   clear          synchronous clear of all accumulated state (beats an event)
//   distance       total pulses since reset/clear, modulo 2^DIST_W
//   speed_avg      floor(sum of last N window counts / N)
//   speed_valid    high once N windows have been accumulated
//   sample_stb     one-cycle pulse: outputs were updated this cycle
//   overflow       sticky; distance has wrapped at least once
// -----------------------------------------------------------------------------
module wheel_odometer #(
  parameter int CNT_W    = 8,
  parameter int DIST_W   = 32,
  parameter int AVG_LOG2 = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [CNT_W-1:0]  pulses_number,
  input  logic              rst_flag,
  input  logic              clear,
  output logic [DIST_W-1:0] distance,
  output logic [CNT_W-1:0]  speed_avg,
  output logic              speed_valid,
  output logic              sample_stb,
  output logic              overflow
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;  // N * max count always fits
  localparam int FILL_W = AVG_LOG2 + 1;      // must be able to hold N itself

  // Registered state
  logic                rst_q;
  logic [CNT_W-1:0]    ring_q [N];
  logic [AVG_LOG2-1:0] wptr_q;
  logic [SUM_W-1:0]    sum_q;
  logic [FILL_W-1:0]   fill_q;
  logic [DIST_W-1:0]   dist_q;
  logic [CNT_W-1:0]    avg_q;
  logic                valid_q;
  logic                stb_q;
  logic                ovf_q;

  // Next-state values, only committed on an event
  logic                event_w;
  logic [SUM_W-1:0]    sum_d;
  logic [FILL_W-1:0]   fill_d;
  logic [DIST_W-1:0]   dist_d;
  logic                carry_d;
  logic [CNT_W-1:0]    avg_d;

  // A held flag is one window: only its rising edge counts.
  assign event_w = rst_flag & ~rst_q;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sum_d   = '0;
    fill_d  = fill_q;
    dist_d  = '0;
    carry_d = 1'b0;
    avg_d   = '0;

    // Entries not yet written are still zero from reset/clear, so the
    // subtraction is correct during the fill phase as well.
    sum_d = sum_q + SUM_W'(pulses_number) - SUM_W'(ring_q[wptr_q]);
    {carry_d, dist_d} = {1'b0, dist_q} + (DIST_W + 1)'(pulses_number);
    avg_d = CNT_W'(sum_d >> AVG_LOG2);

    if (fill_q < FILL_W'(N)) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  // NOTE: the ring buffer is reset and cleared explicitly because unfilled
  // entries must read as zero for the running-sum subtraction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_q   <= 1'b0;
      for (int i = 0; i < N; i++) ring_q[i] <= '0;
      wptr_q  <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      dist_q  <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // Sampled even during clear so a flag held across clear is not recounted.
      rst_q <= rst_flag;

      if (clear) begin
        for (int i = 0; i < N; i++) ring_q[i] <= '0;
        wptr_q  <= '0;
        sum_q   <= '0;
        fill_q  <= '0;
        dist_q  <= '0;
        avg_q   <= '0;
        valid_q <= 1'b0;
        stb_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (event_w) begin
        ring_q[wptr_q] <= pulses_number;
        wptr_q  <= wptr_q + AVG_LOG2'(1);  // N is a power of two: wraps to 0
        sum_q   <= sum_d;
        fill_q  <= fill_d;
        dist_q  <= dist_d;
        avg_q   <= avg_d;
        valid_q <= (fill_d == FILL_W'(N));
        stb_q   <= 1'b1;
        if (carry_d) ovf_q <= 1'b1;
      end else begin
        stb_q <= 1'b0;
      end
    end
  end

  assign distance    = dist_q;
  assign speed_avg   = avg_q;
  assign speed_valid = valid_q;
  assign sample_stb  = stb_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wheel_odometer.sv
// -----------------------------------------------------------------------------
// tb_wheel_odometer
//
// Directed, table-driven bench for wheel_odometer with DIST_W = 10 so the
// distance wrap is reachable with a handful of windows. Each table row gives
// the inputs applied before a rising edge and the outputs expected just after
// it. Reset behaviour is covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_wheel_odometer;

  localparam int CNT_W    = 8;
  localparam int DIST_W   = 10;
  localparam int AVG_LOG2 = 2;

  logic              clk;
  logic              rst_n;
  logic [CNT_W-1:0]  pulses_number;
  logic              rst_flag;
  logic              clear;
  logic [DIST_W-1:0] distance;
  logic [CNT_W-1:0]  speed_avg;
  logic              speed_valid;
  logic              sample_stb;
  logic              overflow;

  wheel_odometer #(
    .CNT_W   (CNT_W),
    .DIST_W  (DIST_W),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .pulses_number(pulses_number),
    .rst_flag     (rst_flag),
    .clear        (clear),
    .distance     (distance),
    .speed_avg    (speed_avg),
    .speed_valid  (speed_valid),
    .sample_stb   (sample_stb),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flag;
    logic [7:0]  pn;
    logic        clr;
    logic [9:0]  e_dist;
    logic [7:0]  e_avg;
    logic        e_valid;
    logic        e_stb;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [9:0] d, input logic [7:0] a,
                               input logic v, input logic s, input logic o);
    check({tag, ".distance"},    32'(distance),    32'(d));
    check({tag, ".speed_avg"},   32'(speed_avg),   32'(a));
    check({tag, ".speed_valid"}, 32'(speed_valid), 32'(v));
    check({tag, ".sample_stb"},  32'(sample_stb),  32'(s));
    check({tag, ".overflow"},    32'(overflow),    32'(o));
  endtask

  task automatic add(input string n, input logic f, input logic [7:0] p, input logic c,
                     input logic [9:0] d, input logic [7:0] a, input logic v,
                     input logic s, input logic o);
    vec_t r;
    r.name = n; r.flag = f; r.pn = p; r.clr = c;
    r.e_dist = d; r.e_avg = a; r.e_valid = v; r.e_stb = s; r.e_ovf = o;
    vecs.push_back(r);
  endtask

  // One clock: inputs are already set; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   name        flag pn  clr  dist avg val stb ovf
    // Fill: 10, 20, 30, 40
    add("fill_w1",    1,  10, 0,   10,   2, 0, 1, 0);
    add("fill_g1",    0,   0, 0,   10,   2, 0, 0, 0);
    add("fill_w2",    1,  20, 0,   30,   7, 0, 1, 0);
    add("fill_g2",    0,   0, 0,   30,   7, 0, 0, 0);
    add("fill_w3",    1,  30, 0,   60,  15, 0, 1, 0);
    add("fill_g3",    0,   0, 0,   60,  15, 0, 0, 0);
    add("fill_w4",    1,  40, 0,  100,  25, 1, 1, 0);
    add("fill_g4",    0,   0, 0,  100,  25, 1, 0, 0);
    // Slide: 0 then 255 (sum 90, then 325)
    add("slide_w0",   1,   0, 0,  100,  22, 1, 1, 0);
    add("slide_g0",   0,   0, 0,  100,  22, 1, 0, 0);
    add("slide_w255", 1, 255, 0,  355,  81, 1, 1, 0);
    add("slide_g255", 0,   0, 0,  355,  81, 1, 0, 0);
    // Held strobe: 5 cycles high, count changes after the first (sum 302)
    add("held_c1",    1,   7, 0,  362,  75, 1, 1, 0);
    add("held_c2",    1,  99, 0,  362,  75, 1, 0, 0);
    add("held_c3",    1,  99, 0,  362,  75, 1, 0, 0);
    add("held_c4",    1,  99, 0,  362,  75, 1, 0, 0);
    add("held_c5",    1,  99, 0,  362,  75, 1, 0, 0);
    add("held_end",   0,   0, 0,  362,  75, 1, 0, 0);
    // Plain clear
    add("clear",      0,   0, 1,    0,   0, 0, 0, 0);
    // Overflow: five windows of 255 on a 10-bit accumulator
    add("ovf_w1",     1, 255, 0,  255,  63, 0, 1, 0);
    add("ovf_g1",     0,   0, 0,  255,  63, 0, 0, 0);
    add("ovf_w2",     1, 255, 0,  510, 127, 0, 1, 0);
    add("ovf_g2",     0,   0, 0,  510, 127, 0, 0, 0);
    add("ovf_w3",     1, 255, 0,  765, 191, 0, 1, 0);
    add("ovf_g3",     0,   0, 0,  765, 191, 0, 0, 0);
    add("ovf_w4",     1, 255, 0, 1020, 255, 1, 1, 0);
    add("ovf_g4",     0,   0, 0, 1020, 255, 1, 0, 0);
    add("ovf_w5",     1, 255, 0,  251, 255, 1, 1, 1);
    add("ovf_g5",     0,   0, 0,  251, 255, 1, 0, 1);
    add("ovf_hold",   0,   0, 0,  251, 255, 1, 0, 1);
    // clear coincident with a flag rise; flag stays high after clear
    add("clr_evt",    1,  50, 1,    0,   0, 0, 0, 0);
    add("clr_held",   1,  50, 0,    0,   0, 0, 0, 0);
    add("clr_low",    0,   0, 0,    0,   0, 0, 0, 0);
    add("post_w12",   1,  12, 0,   12,   3, 0, 1, 0);
    add("post_g12",   0,   0, 0,   12,   3, 0, 0, 0);

    // Reset state
    rst_n = 1'b0; rst_flag = 1'b0; pulses_number = '0; clear = 1'b0;
    tick();
    tick();
    check_outputs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_outputs("post_reset_idle", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst_flag      = vecs[i].flag;
      pulses_number = vecs[i].pn;
      clear         = vecs[i].clr;
      tick();
      check_outputs(vecs[i].name, vecs[i].e_dist, vecs[i].e_avg,
                    vecs[i].e_valid, vecs[i].e_stb, vecs[i].e_ovf);
    end

    // Asynchronous reset mid-run: distance is 12, outputs must drop before
    // any clock edge. Also arm a window so the stb is high when reset hits.
    rst_flag = 1'b1; pulses_number = 8'd4;
    tick();
    check_outputs("pre_async", 16, 4, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0, 0);
    // Flag stays high through reset; still zero while reset is held.
    pulses_number = 8'd5;
    tick();
    check_outputs("reset_held", 0, 0, 0, 0, 0);
    // First edge after release with the flag already high is an event.
    rst_n = 1'b1;
    tick();
    check_outputs("first_edge_evt", 5, 1, 0, 1, 0);
    tick();
    check_outputs("first_edge_held", 5, 1, 0, 0, 0);
    rst_flag = 1'b0;
    tick();
    check_outputs("final_idle", 5, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
